// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit merge stage: byte width, drain FSM
// encoding and the saturating drop-counter adder.
package uart_pkg;

  localparam int BYTE_W     = 8;
  localparam int DROP_CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } drain_st_t;

  function automatic logic [DROP_CNT_W-1:0] sat_add_drop(
    input logic [DROP_CNT_W-1:0] i_acc,
    input logic [1:0]            i_inc
  );
    logic [DROP_CNT_W:0] w_sum;
    w_sum = {1'b0, i_acc} + {{(DROP_CNT_W-1){1'b0}}, i_inc};
    return w_sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : w_sum[DROP_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/uart_tx_merge_fifo_if.sv
// Bundle of the two byte sources, the transmitter handshake and FIFO status.
// slave = the merge block, master = whoever drives the sources and the transmitter side.
interface uart_tx_merge_fifo_if
  import uart_pkg::*;
#(
  parameter int DW    = BYTE_W,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  a_valid;
  logic [DW-1:0]         a_data;
  logic                  b_valid;
  logic [DW-1:0]         b_data;
  logic                  tx_rdy;
  logic                  tx_en;
  logic [DW-1:0]         tx_data;
  logic [CW-1:0]         count;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  ovf_clr;
  logic [DROP_CNT_W-1:0] drop_cnt;

  modport slave (
    input  a_valid, a_data, b_valid, b_data, tx_rdy, ovf_clr,
    output tx_en, tx_data, count, empty, full, overflow, drop_cnt
  );

  modport master (
    output a_valid, a_data, b_valid, b_data, tx_rdy, ovf_clr,
    input  tx_en, tx_data, count, empty, full, overflow, drop_cnt
  );

endinterface

// File: rtl/byte_fifo_2w.sv
// Circular byte store accepting up to two writes (A then B) and one read per cycle.
// Free space is judged on the start-of-cycle count; a same-cycle read does not free a slot.
module byte_fifo_2w #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_a_valid,
  input  logic [DW-1:0]              i_a_data,
  input  logic                       i_b_valid,
  input  logic [DW-1:0]              i_b_data,
  input  logic                       i_rd,
  output logic [DW-1:0]              o_rd_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [1:0]                 o_drops
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic [CW-1:0] w_space;
  logic          w_has1;
  logic          w_has2;
  logic          w_wr_a;
  logic          w_wr_b;
  logic [1:0]    w_nwr;
  logic [DW-1:0] w_d0;

  assign w_space = CW'(DEPTH) - r_count;
  assign w_has1  = (w_space != '0);
  assign w_has2  = (w_space >= CW'(2));
  // A has fixed priority: B only gets a slot if one is left after A.
  assign w_wr_a  = i_a_valid & w_has1;
  assign w_wr_b  = i_b_valid & (i_a_valid ? w_has2 : w_has1);
  assign w_nwr   = {1'b0, w_wr_a} + {1'b0, w_wr_b};
  assign w_d0    = w_wr_a ? i_a_data : i_b_data;
  assign o_drops = ({1'b0, i_a_valid} + {1'b0, i_b_valid}) - w_nwr;

  always_ff @(posedge clk) begin
    if (w_wr_a | w_wr_b) r_mem[r_wptr] <= w_d0;
    if (w_wr_a & w_wr_b) r_mem[r_wptr + AW'(1)] <= i_b_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_nwr);
      if (i_rd) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_nwr) - CW'(i_rd);
    end
  end

  assign o_rd_data = r_mem[r_rptr];
  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));

endmodule

// File: rtl/uart_tx_merge_fifo.sv
// Merges two byte strobes into one FIFO and drains it into a UART transmitter via en/rdy.
// Define UART_TX_MERGE_DROP_CNT_EN to build the saturating dropped-byte counter.
module uart_tx_merge_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int DW      = BYTE_W,
  parameter int HOLDOFF = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_tx_merge_fifo_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int HW = $clog2(HOLDOFF + 1);

  logic          w_rd;
  logic [DW-1:0] w_rd_data;
  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  logic [1:0]    w_drops;

  drain_st_t     r_state;
  logic [HW-1:0] r_hold;
  logic          r_tx_en;
  logic [DW-1:0] r_tx_data;
  logic          r_ovf;

  byte_fifo_2w #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_a_valid (bus.a_valid),
    .i_a_data  (bus.a_data),
    .i_b_valid (bus.b_valid),
    .i_b_data  (bus.b_data),
    .i_rd      (w_rd),
    .o_rd_data (w_rd_data),
    .o_count   (w_count),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_drops   (w_drops)
  );

  assign w_rd = (r_state == ST_IDLE) && !w_empty && bus.tx_rdy;

  // tx_rdy is ignored while holding off, since the transmitter drops rdy a few cycles late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_hold    <= '0;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx_en <= w_rd;
          if (w_rd) begin
            r_tx_data <= w_rd_data;
            r_hold    <= HW'(HOLDOFF);
            r_state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          r_tx_en <= 1'b0;
          r_hold  <= r_hold - HW'(1);
          if (r_hold <= HW'(1)) r_state <= ST_IDLE;
        end
        default: begin
          r_tx_en <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drops != 2'd0) begin
      r_ovf <= 1'b1;
    end else if (bus.ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

`ifdef UART_TX_MERGE_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drops != 2'd0) begin
      r_drop_cnt <= bus.ovf_clr ? DROP_CNT_W'(w_drops) : sat_add_drop(r_drop_cnt, w_drops);
    end else if (bus.ovf_clr) begin
      r_drop_cnt <= '0;
    end
  end

  assign bus.drop_cnt = r_drop_cnt;
`else
  assign bus.drop_cnt = '0;
`endif

  assign bus.tx_en    = r_tx_en;
  assign bus.tx_data  = r_tx_data;
  assign bus.count    = w_count;
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_uart_tx_merge_fifo.sv
// Bench for uart_tx_merge_fifo: random and directed stimulus against a queue-based model.
module tb_uart_tx_merge_fifo;
  import uart_pkg::*;

  localparam int DEPTH   = 16;
  localparam int DW      = 8;
  localparam int HOLDOFF = 2;
`ifdef UART_TX_MERGE_DROP_CNT_EN
  localparam int DROP_EN = 1;
`else
  localparam int DROP_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [7:0] mq[$];
  int         m_cool;
  bit         m_txen;
  logic [7:0] m_txdata;
  bit         m_ovf;
  int         m_drop;

  uart_tx_merge_fifo_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  uart_tx_merge_fifo #(
    .DEPTH   (DEPTH),
    .DW      (DW),
    .HOLDOFF (HOLDOFF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    mq.delete();
    m_cool   = 0;
    m_txen   = 1'b0;
    m_txdata = 8'h00;
    m_ovf    = 1'b0;
    m_drop   = 0;
  endtask

  // Drive one cycle of inputs, step the model over the edge, sample 1ns later.
  task automatic cycle(input bit av, input logic [7:0] ad, input bit bv,
                       input logic [7:0] bd, input bit rdy, input bit clr);
    int         space;
    int         nd;
    bit         rd;
    logic [7:0] d;
    d = 8'h00;
    bus.a_valid = av;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_data  = bd;
    bus.tx_rdy  = rdy;
    bus.ovf_clr = clr;
    @(posedge clk);
    space = DEPTH - mq.size();
    nd    = 0;
    rd    = (m_cool == 0) && (mq.size() > 0) && rdy;
    if (rd) d = mq.pop_front();
    if (av) begin
      if (space >= 1) begin mq.push_back(ad); space--; end
      else nd++;
    end
    if (bv) begin
      if (space >= 1) begin mq.push_back(bd); space--; end
      else nd++;
    end
    if (rd) begin
      m_txen = 1'b1; m_txdata = d; m_cool = HOLDOFF;
    end else begin
      m_txen = 1'b0;
      if (m_cool > 0) m_cool--;
    end
    if (nd > 0) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (DROP_EN != 0) begin
      if (nd > 0) m_drop = clr ? nd : ((m_drop + nd > 255) ? 255 : m_drop + nd);
      else if (clr) m_drop = 0;
    end
    #1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.ovf_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.ovf_clr = 1'b0;
    bus.tx_rdy  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.a_data = 8'h00;
    bus.b_data = 8'h00;
    do_reset();
    checks++; if (bus.count !== 5'd0)    begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++; if (bus.empty !== 1'b1)    begin errors++; $display("FAIL reset_empty got %b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0)     begin errors++; $display("FAIL reset_full got %b want 0", bus.full); end
    checks++; if (bus.tx_en !== 1'b0)    begin errors++; $display("FAIL reset_tx_en got %b want 0", bus.tx_en); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
    checks++; if (bus.drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d want 0", bus.drop_cnt); end
  endtask

  task automatic test_single_byte();
    do_reset();
    repeat (4) cycle(0, 8'h00, 0, 8'h00, 1, 0);
    cycle(1, 8'h47, 0, 8'h00, 1, 0);
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL single_count1 got %0d want 1", bus.count); end
    checks++; if (bus.tx_en !== 1'b0) begin errors++; $display("FAIL single_early_en got %b want 0", bus.tx_en); end
    cycle(0, 8'h00, 0, 8'h00, 1, 0);
    checks++; if (bus.tx_en !== 1'b1 || bus.tx_data !== 8'h47) begin
      errors++; $display("FAIL single_tx got en=%b data=%h want en=1 data=47", bus.tx_en, bus.tx_data);
    end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL single_count0 got %0d want 0", bus.count); end
    cycle(0, 8'h00, 0, 8'h00, 1, 0);
    checks++; if (bus.tx_en !== 1'b0 || bus.tx_data !== 8'h47) begin
      errors++; $display("FAIL single_hold got en=%b data=%h want en=0 data=47", bus.tx_en, bus.tx_data);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] got[$];
    int         t_pulse[$];
    do_reset();
    cycle(1, 8'h41, 1, 8'h42, 0, 0);
    checks++; if (bus.count !== 5'd2) begin errors++; $display("FAIL simul_count got %0d want 2", bus.count); end
    for (int c = 0; c < 12; c++) begin
      cycle(0, 8'h00, 0, 8'h00, 1, 0);
      checks++; if (bus.tx_en !== m_txen || bus.tx_data !== m_txdata) begin
        errors++; $display("FAIL simul_cycle%0d got en=%b data=%h want en=%b data=%h", c, bus.tx_en, bus.tx_data, m_txen, m_txdata);
      end
      if (bus.tx_en === 1'b1) begin got.push_back(bus.tx_data); t_pulse.push_back(c); end
    end
    checks++; if (got.size() != 2) begin
      errors++; $display("FAIL simul_pulses got %0d want 2", got.size());
    end else begin
      checks++; if (got[0] !== 8'h41 || got[1] !== 8'h42) begin
        errors++; $display("FAIL simul_order got %h,%h want 41,42", got[0], got[1]);
      end
      checks++; if (t_pulse[1] - t_pulse[0] < HOLDOFF + 1) begin
        errors++; $display("FAIL simul_gap got %0d want >= %0d", t_pulse[1] - t_pulse[0], HOLDOFF + 1);
      end
    end
  endtask

  task automatic test_fill_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'($urandom_range(0, 255)), 0, 8'h00, 0, 0);
    checks++; if (bus.full !== 1'b1 || bus.count !== 5'd16) begin
      errors++; $display("FAIL fill_full got full=%b count=%0d want full=1 count=16", bus.full, bus.count);
    end
    cycle(1, 8'hEE, 0, 8'h00, 0, 0);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf got %b want 1", bus.overflow); end
    checks++; if (int'(bus.drop_cnt) !== DROP_EN) begin errors++; $display("FAIL fill_drop got %0d want %0d", bus.drop_cnt, DROP_EN); end
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL fill_count17 got %0d want 16", bus.count); end
    cycle(0, 8'h00, 0, 8'h00, 0, 1);
    checks++; if (bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0) begin
      errors++; $display("FAIL fill_clr got ovf=%b drop=%0d want 0/0", bus.overflow, bus.drop_cnt);
    end
    // full and drain in the same cycle: read happens, incoming byte is still dropped
    cycle(1, 8'hDD, 0, 8'h00, 1, 1);
    checks++; if (bus.count !== 5'd15 || bus.tx_en !== 1'b1) begin
      errors++; $display("FAIL fill_drain_count got count=%0d en=%b want 15/1", bus.count, bus.tx_en);
    end
    checks++; if (bus.overflow !== 1'b1 || int'(bus.drop_cnt) !== m_drop) begin
      errors++; $display("FAIL fill_drain_ovf got ovf=%b drop=%0d want 1/%0d", bus.overflow, bus.drop_cnt, m_drop);
    end
    for (int c = 0; c < 60; c++) begin
      cycle(0, 8'h00, 0, 8'h00, 1, 0);
      checks++; if (bus.tx_en !== m_txen || bus.tx_data !== m_txdata) begin
        errors++; $display("FAIL fill_drain%0d got en=%b data=%h want en=%b data=%h", c, bus.tx_en, bus.tx_data, m_txen, m_txdata);
      end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL fill_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_space_one();
    logic [7:0] last;
    last = 8'h00;
    do_reset();
    for (int i = 0; i < DEPTH - 1; i++) cycle(1, 8'(i), 0, 8'h00, 0, 0);
    cycle(1, 8'hAA, 1, 8'hBB, 0, 0);
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL space1_count got %0d want 16", bus.count); end
    checks++; if (int'(bus.drop_cnt) !== DROP_EN || bus.overflow !== 1'b1) begin
      errors++; $display("FAIL space1_drop got drop=%0d ovf=%b want %0d/1", bus.drop_cnt, bus.overflow, DROP_EN);
    end
    for (int c = 0; c < 60; c++) begin
      cycle(0, 8'h00, 0, 8'h00, 1, 0);
      if (bus.tx_en === 1'b1) last = bus.tx_data;
    end
    checks++; if (last !== 8'hAA) begin errors++; $display("FAIL space1_last got %h want AA", last); end
  endtask

  task automatic test_pointer_wrap();
    logic [7:0] sent[$];
    logic [7:0] got[$];
    int         injected;
    bit         done;
    bit         av, bv, rdy;
    logic [7:0] ad, bd;
    injected = 0;
    done     = 1'b0;
    do_reset();
    for (int c = 0; c < 3000 && !done; c++) begin
      av = 1'b0; bv = 1'b0;
      ad = 8'($urandom_range(0, 255));
      bd = 8'($urandom_range(0, 255));
      rdy = 1'($urandom_range(0, 1));
      if (injected < 40 && mq.size() < DEPTH - 2 && $urandom_range(0, 2) == 0) begin
        av = 1'b1; sent.push_back(ad); injected++;
        if (injected < 40 && $urandom_range(0, 1) == 1) begin
          bv = 1'b1; sent.push_back(bd); injected++;
        end
      end
      cycle(av, ad, bv, bd, rdy, 0);
      checks++; if (bus.tx_en !== m_txen || bus.tx_data !== m_txdata || int'(bus.count) !== mq.size()) begin
        errors++; $display("FAIL wrap_cycle%0d got en=%b data=%h cnt=%0d want en=%b data=%h cnt=%0d",
                            c, bus.tx_en, bus.tx_data, bus.count, m_txen, m_txdata, mq.size());
      end
      if (bus.tx_en === 1'b1) got.push_back(bus.tx_data);
      if (injected == 40 && mq.size() == 0 && m_cool == 0) done = 1'b1;
    end
    checks++; if (!done) begin errors++; $display("FAIL wrap_timeout got injected=%0d left=%0d want drained", injected, mq.size()); end
    checks++; if (got.size() != 40) begin
      errors++; $display("FAIL wrap_size got %0d want 40", got.size());
    end else begin
      for (int i = 0; i < 40; i++) begin
        checks++; if (got[i] !== sent[i]) begin
          errors++; $display("FAIL wrap_order idx %0d got %h want %h", i, got[i], sent[i]);
        end
      end
    end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf got %b want 0", bus.overflow); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 8'h60 + 8'(i), 0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 8'h00, 1, 0);
    checks++; if (bus.tx_en !== 1'b1) begin errors++; $display("FAIL areset_pre_en got %b want 1", bus.tx_en); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.tx_en !== 1'b0 || bus.count !== 5'd0 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL areset_now got en=%b count=%0d empty=%b want 0/0/1", bus.tx_en, bus.count, bus.empty);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cycle(0, 8'h00, 0, 8'h00, 1, 0);
      checks++; if (bus.tx_en !== 1'b0) begin errors++; $display("FAIL areset_stale cycle %0d got en=1 want 0", c); end
    end
  endtask

  initial begin
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.tx_rdy  = 1'b0;
    bus.ovf_clr = 1'b0;
    test_reset();
    test_single_byte();
    test_simultaneous();
    test_fill_full();
    test_space_one();
    test_pointer_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_merge_fifo.md
Name: uart_tx_merge_fifo

Overview:
- Buffered merge stage that sits directly upstream of a uart_tx_sol instance.
- Takes two byte sources as single-cycle valid pulses (e.g. gold and silver uart_rx_sol outputs) and queues them into one FIFO.
- Drains the FIFO into the transmitter using its en/rdy handshake.
- Replaces unbuffered forwarding, where a byte is lost whenever both sources fire together or the transmitter is busy.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
DW, 8, data width in bits
HOLDOFF, 2, cycles after a tx_en pulse during which tx_rdy is ignored (covers transmitter rdy-drop latency); >= 1

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
a_valid  in  1  source A byte strobe, one cycle per byte
a_data  in  DW  source A byte, sampled when a_valid=1
b_valid  in  1  source B byte strobe
b_data  in  DW  source B byte
tx_rdy  in  1  transmitter ready
tx_en  out  1  transmit strobe, one-cycle pulse
tx_data  out  DW  byte to transmit; held stable between pulses
count  out  $clog2(DEPTH)+1  current occupancy
empty  out  1  count==0
full  out  1  count==DEPTH
overflow  out  1  sticky: a byte was dropped
ovf_clr  in  1  clears overflow
drop_cnt  out  8  dropped-byte count (see Optional Feature)

Behaviour:
- Reset (rst_n=0, async, takes effect without clk): pointers=0, count=0, empty=1, full=0, tx_en=0, tx_data=0, overflow=0, drop_cnt=0, FSM=IDLE; FIFO contents discarded. Reset mid-transmit cancels any pending tx_en immediately.
- Write side: free space is evaluated as DEPTH-count at the start of the cycle. A slot freed by a same-cycle read is not usable until the next cycle.
  - Both valid, space>=2: A written at wptr, B at wptr+1, wptr+=2.
  - Both valid, space==1: A written, B dropped (A has fixed priority).
  - Single valid, space>=1: written.
  - Any valid with space==0: dropped.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is updated as count + writes - read; writes is 0..2, read is 0..1.
- Every dropped byte sets overflow the next cycle. If a drop and ovf_clr occur in the same cycle, set wins.
- Drain FSM states: IDLE, HOLD.
  - IDLE: if !empty && tx_rdy, then on the next edge: tx_en=1, tx_data=mem[rptr], rptr+=1, count decremented, holdoff counter loaded with HOLDOFF, go to HOLD.
  - HOLD: tx_en=0; counter decrements each cycle; return to IDLE when it reaches 0. tx_rdy is not sampled in HOLD.
- tx_en is never high two cycles in a row. tx_data changes only on the edge that raises tx_en.
- Latency: with FIFO empty, FSM in IDLE and tx_rdy=1, a_valid in cycle k gives tx_en in cycle k+2.
- Ordering: FIFO order is preserved; within one cycle, A precedes B.
- Full and drain in the same cycle: the read occurs, but incoming bytes are still dropped that cycle.

Optional Feature:
- Macro: UART_TX_MERGE_DROP_CNT_EN
- Defined: drop_cnt is an 8-bit counter.
  - Increments by the number of bytes dropped per cycle (0..2) and saturates at 255.
  - Cleared by ovf_clr only when no drop occurs that cycle; otherwise it loads the drop amount.
- Undefined: drop_cnt is tied to 0 and no counter logic is synthesised. The overflow flag is unaffected.

Decomposition:
- Shared package uart_pkg: BYTE_W=8, drain FSM state encoding (IDLE, HOLD), DROP_CNT_W=8.
- One natural sub-module, byte_fifo_2w: storage, dual-write pointer logic, count, full/empty.
- The top level holds the drain FSM, holdoff counter, overflow flag and drop counter.

Test Plan:
- Single byte: reset, tx_rdy=1, a_valid with a_data=0x47 in cycle 5 -> tx_en in cycle 7 with tx_data=0x47; count goes 0→1→0.
- Simultaneous write: a=0x41 and b=0x42 in the same cycle, tx_rdy=0 -> count=2. Release tx_rdy -> tx_data 0x41 then 0x42; the two pulses are at least HOLDOFF+1 cycles apart.
- Fill to full: 16 A writes, tx_rdy=0 -> full=1, count=16. A 17th write -> dropped, overflow=1, drop_cnt=1; ovf_clr -> overflow=0.
- Space==1 collision: 15 entries queued, A and B fire together -> A stored, B dropped; count=16, drop_cnt=1.
- Pointer wrap: 40 bytes streamed with tx_rdy toggling randomly -> output order matches input order and no drops.
- Async reset mid-operation: rst_n low while 5 bytes are queued and tx_en is pending -> tx_en=0 and count=0 immediately; no stale byte is transmitted after rst_n returns high.
